// File: rtl/frontier_sched.sv
// Front-end for the Dijkstra frontier queue: round-robin push arbitration into a
// single write slot, plus a pop sequencer that drains pending pushes before reading.
module frontier_sched #(
  parameter int W_D       = 32,
  parameter int NUM_PORTS = 4,
  parameter int W_CNT     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic [NUM_PORTS-1:0]     wr_valid,
  output logic [NUM_PORTS-1:0]     wr_ready,
  input  logic [NUM_PORTS*W_D-1:0] wr_node_addr,
  input  logic [NUM_PORTS*W_D-1:0] wr_cost,
  input  logic                     pop_req,
  output logic                     pop_busy,
  output logic                     pop_valid,
  output logic [W_D-1:0]           pop_node_addr,
  output logic [W_D-1:0]           pop_cost,
  output logic                     pop_empty,
  output logic                     fe_write_valid,
  input  logic                     fe_write_ready,
  output logic [W_D-1:0]           fe_write_node_addr,
  output logic [W_D-1:0]           fe_write_cost,
  output logic                     fe_read_req_valid,
  input  logic                     fe_read_req_ready,
  input  logic                     fe_read_data_valid,
  input  logic [W_D-1:0]           fe_read_node_addr,
  input  logic [W_D-1:0]           fe_read_cost,
  input  logic                     fe_read_empty,
  output logic [W_CNT-1:0]         push_count,
  output logic [W_CNT-1:0]         pop_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          any_grant;
  logic          slot_free;
  logic          grant_en;
  logic [1:0]    settle;
  int            scan;

  assign slot_free = !fe_write_valid || fe_write_ready;
  assign grant_en  = slot_free && (state == IDLE);
  assign pop_busy  = (state != IDLE);

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    wr_ready  = '0;
    win_idx   = '0;
    any_grant = 1'b0;
    scan      = 0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      cand = PW'(scan);
      if (grant_en && !any_grant && wr_valid[cand]) begin
        any_grant = 1'b1;
        win_idx   = cand;
      end
    end
    if (any_grant) wr_ready[win_idx] = 1'b1;
  end

  // Write slot and arbitration pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      fe_write_valid     <= 1'b0;
      fe_write_node_addr <= '0;
      fe_write_cost      <= '0;
      rr_ptr             <= '0;
    end else begin
      if (slot_free) fe_write_valid <= any_grant;
      if (any_grant) begin
        fe_write_node_addr <= wr_node_addr[int'(win_idx)*W_D +: W_D];
        fe_write_cost      <= wr_cost[int'(win_idx)*W_D +: W_D];
        rr_ptr             <= (win_idx == PW'(NUM_PORTS-1)) ? '0 : win_idx + 1'b1;
      end
      if (clear) rr_ptr <= '0;
    end
  end

  // Statistics
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      push_count <= '0;
      pop_count  <= '0;
    end else begin
      if (fe_write_valid && fe_write_ready) push_count <= push_count + 1'b1;
      if (pop_valid && !pop_empty)          pop_count  <= pop_count + 1'b1;
    end
  end

  // Pop sequencer; DRAIN waits for an empty slot plus two settle cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      settle            <= '0;
      fe_read_req_valid <= 1'b0;
      pop_valid         <= 1'b0;
      pop_empty         <= 1'b0;
      pop_node_addr     <= '0;
      pop_cost          <= '0;
    end else begin
      pop_valid <= 1'b0;
      pop_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_req) begin
            state  <= DRAIN;
            settle <= '0;
          end
        end
        DRAIN: begin
          if (fe_write_valid) begin
            settle <= '0;
          end else if (settle != 2'd2) begin
            settle <= settle + 1'b1;
          end else if (fe_read_empty) begin
            pop_valid     <= 1'b1;
            pop_empty     <= 1'b1;
            pop_node_addr <= '0;
            pop_cost      <= '0;
            state         <= IDLE;
          end else begin
            fe_read_req_valid <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (fe_read_empty) begin
            fe_read_req_valid <= 1'b0;
            pop_valid         <= 1'b1;
            pop_empty         <= 1'b1;
            pop_node_addr     <= '0;
            pop_cost          <= '0;
            state             <= IDLE;
          end else if (fe_read_req_ready) begin
            fe_read_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (fe_read_data_valid) begin
            pop_valid     <= 1'b1;
            pop_node_addr <= fe_read_node_addr;
            pop_cost      <= fe_read_cost;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frontier_sched.sv
// Directed bench for frontier_sched: push arbitration, write-slot stall, drain-before-pop,
// empty pops, read-request backpressure and mid-pop reset.
module tb_frontier_sched;

  localparam int W_D = 32;
  localparam int NP  = 4;
  localparam int W_CNT = 32;

  logic              CLK;
  logic              RST;
  logic              clear;
  logic [NP-1:0]     wr_valid;
  logic [NP-1:0]     wr_ready;
  logic [NP*W_D-1:0] wr_node_addr;
  logic [NP*W_D-1:0] wr_cost;
  logic              pop_req;
  logic              pop_busy;
  logic              pop_valid;
  logic [W_D-1:0]    pop_node_addr;
  logic [W_D-1:0]    pop_cost;
  logic              pop_empty;
  logic              fe_write_valid;
  logic              fe_write_ready;
  logic [W_D-1:0]    fe_write_node_addr;
  logic [W_D-1:0]    fe_write_cost;
  logic              fe_read_req_valid;
  logic              fe_read_req_ready;
  logic              fe_read_data_valid;
  logic [W_D-1:0]    fe_read_node_addr;
  logic [W_D-1:0]    fe_read_cost;
  logic              fe_read_empty;
  logic [W_CNT-1:0]  push_count;
  logic [W_CNT-1:0]  pop_count;

  int n_checks = 0;
  int n_fail   = 0;

  frontier_sched #(.W_D(W_D), .NUM_PORTS(NP), .W_CNT(W_CNT)) dut (
    .CLK(CLK), .RST(RST), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_node_addr(wr_node_addr), .wr_cost(wr_cost),
    .pop_req(pop_req), .pop_busy(pop_busy), .pop_valid(pop_valid),
    .pop_node_addr(pop_node_addr), .pop_cost(pop_cost), .pop_empty(pop_empty),
    .fe_write_valid(fe_write_valid), .fe_write_ready(fe_write_ready),
    .fe_write_node_addr(fe_write_node_addr), .fe_write_cost(fe_write_cost),
    .fe_read_req_valid(fe_read_req_valid), .fe_read_req_ready(fe_read_req_ready),
    .fe_read_data_valid(fe_read_data_valid), .fe_read_node_addr(fe_read_node_addr),
    .fe_read_cost(fe_read_cost), .fe_read_empty(fe_read_empty),
    .push_count(push_count), .pop_count(pop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input int p, input logic [W_D-1:0] node, input logic [W_D-1:0] cost);
    wr_node_addr[p*W_D +: W_D] = node;
    wr_cost[p*W_D +: W_D]      = cost;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  req_seen;

    RST = 1'b1; clear = 1'b0; wr_valid = '0; wr_node_addr = '0; wr_cost = '0;
    pop_req = 1'b0; fe_write_ready = 1'b1; fe_read_req_ready = 1'b0;
    fe_read_data_valid = 1'b0; fe_read_node_addr = '0; fe_read_cost = '0;
    fe_read_empty = 1'b1;
    tick(); tick(); tick();
    RST = 1'b0;
    #1;

    // Reset state
    check("rst_wr_ready", 64'(wr_ready), 64'h0);
    check("rst_fe_wv", 64'(fe_write_valid), 64'h0);
    check("rst_busy", 64'(pop_busy), 64'h0);
    check("rst_pop_valid", 64'(pop_valid), 64'h0);
    check("rst_req", 64'(fe_read_req_valid), 64'h0);
    check("rst_push_cnt", 64'(push_count), 64'h0);
    check("rst_pop_cnt", 64'(pop_count), 64'h0);

    // Single push on port 2
    set_port(2, 32'd5, 32'd9);
    wr_valid = 4'b0100;
    #1;
    check("p2_grant", 64'(wr_ready), 64'h4);
    tick();
    wr_valid = '0;
    check("p2_wv", 64'(fe_write_valid), 64'h1);
    check("p2_node", 64'(fe_write_node_addr), 64'd5);
    check("p2_cost", 64'(fe_write_cost), 64'd9);
    tick();
    check("p2_push_cnt", 64'(push_count), 64'd1);
    check("p2_wv_off", 64'(fe_write_valid), 64'h0);
    pulse_clear();
    check("clr_push_cnt", 64'(push_count), 64'd0);

    // All ports requesting: rotation 0,1,2,3,0 then a 3-cycle stall
    for (int i = 0; i < NP; i++) set_port(i, 32'(100 + i), 32'(200 + i));
    wr_valid = 4'hF;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("rr_grant%0d", c), 64'(wr_ready), 64'(1 << (c % 4)));
      tick();
      check($sformatf("rr_node%0d", c), 64'(fe_write_node_addr), 64'(100 + (c % 4)));
    end
    fe_write_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check("stall_grant", 64'(wr_ready), 64'h0);
      check("stall_wv", 64'(fe_write_valid), 64'h1);
      check("stall_node", 64'(fe_write_node_addr), 64'd100);
      check("stall_cost", 64'(fe_write_cost), 64'd200);
      tick();
    end
    fe_write_ready = 1'b1;
    #1;
    check("resume_grant", 64'(wr_ready), 64'h2);
    tick();
    wr_valid = '0;
    check("resume_node", 64'(fe_write_node_addr), 64'd101);
    tick();
    check("rr_wv_off", 64'(fe_write_valid), 64'h0);
    check("rr_push_cnt", 64'(push_count), 64'd6);
    pulse_clear();

    // Push 30,10,20 then pop: drain, settle, read
    fe_read_empty = 1'b0;
    fe_read_req_ready = 1'b1;
    set_port(0, 32'd1, 32'd30);
    set_port(1, 32'd2, 32'd10);
    set_port(2, 32'd3, 32'd20);
    wr_valid = 4'b0001; tick();
    wr_valid = 4'b0010; tick();
    wr_valid = 4'b0100; tick();
    wr_valid = '0;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    wr_valid = 4'hF;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_req%0d", k), 64'(fe_read_req_valid), 64'h0);
      check($sformatf("drain_busy%0d", k), 64'(pop_busy), 64'h1);
      check($sformatf("drain_nogrant%0d", k), 64'(wr_ready), 64'h0);
      check($sformatf("drain_wv%0d", k), 64'(fe_write_valid), 64'h0);
      tick();
    end
    check("pop_req_on", 64'(fe_read_req_valid), 64'h1);
    check("pop_req_nogrant", 64'(wr_ready), 64'h0);
    tick();
    check("pop_req_off", 64'(fe_read_req_valid), 64'h0);
    check("pop_wait_pv", 64'(pop_valid), 64'h0);
    fe_read_data_valid = 1'b1;
    fe_read_node_addr  = 32'd2;
    fe_read_cost       = 32'd10;
    tick();
    fe_read_data_valid = 1'b0;
    check("pop_pv", 64'(pop_valid), 64'h1);
    check("pop_empty", 64'(pop_empty), 64'h0);
    check("pop_node", 64'(pop_node_addr), 64'd2);
    check("pop_cost", 64'(pop_cost), 64'd10);
    check("pop_busy_off", 64'(pop_busy), 64'h0);
    check("pop_grant_resume", 64'(wr_ready), 64'h8);
    wr_valid = '0;
    tick();
    check("pop_pv_pulse", 64'(pop_valid), 64'h0);
    check("pop_cnt1", 64'(pop_count), 64'd1);
    check("pop_push_cnt", 64'(push_count), 64'd3);

    // Empty frontier pop
    fe_read_empty = 1'b1;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    cyc = 1;
    req_seen = 1'b0;
    while (!pop_valid && cyc < 12) begin
      if (fe_read_req_valid) req_seen = 1'b1;
      tick();
      cyc++;
    end
    check("empty_pv", 64'(pop_valid), 64'h1);
    check("empty_lat", 64'(cyc), 64'd4);
    check("empty_flag", 64'(pop_empty), 64'h1);
    check("empty_node", 64'(pop_node_addr), 64'd0);
    check("empty_cost", 64'(pop_cost), 64'd0);
    check("empty_noreq", 64'(req_seen), 64'h0);
    tick();
    check("empty_pop_cnt", 64'(pop_count), 64'd1);
    check("empty_busy", 64'(pop_busy), 64'h0);

    // Read request backpressure, data 3 cycles after handshake
    fe_read_empty = 1'b0;
    fe_read_req_ready = 1'b0;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_req%0d", i), 64'(fe_read_req_valid), 64'h1);
      tick();
    end
    fe_read_req_ready = 1'b1;
    #1;
    check("bp_req_hs", 64'(fe_read_req_valid), 64'h1);
    tick();
    fe_read_req_ready = 1'b0;
    check("bp_req_drop", 64'(fe_read_req_valid), 64'h0);
    tick();
    check("bp_wait_pv", 64'(pop_valid), 64'h0);
    tick();
    fe_read_data_valid = 1'b1;
    fe_read_node_addr  = 32'd77;
    fe_read_cost       = 32'd44;
    tick();
    fe_read_data_valid = 1'b0;
    check("bp_pv", 64'(pop_valid), 64'h1);
    check("bp_node", 64'(pop_node_addr), 64'd77);
    check("bp_cost", 64'(pop_cost), 64'd44);
    tick();
    check("bp_pop_cnt", 64'(pop_count), 64'd2);

    // Reset while waiting for read data
    fe_read_req_ready = 1'b1;
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    tick(); tick(); tick();
    tick();
    fe_read_req_ready = 1'b0;
    check("rstw_busy_pre", 64'(pop_busy), 64'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstw_busy", 64'(pop_busy), 64'h0);
    check("rstw_req", 64'(fe_read_req_valid), 64'h0);
    check("rstw_push_cnt", 64'(push_count), 64'd0);
    check("rstw_pop_cnt", 64'(pop_count), 64'd0);
    fe_read_data_valid = 1'b1;
    fe_read_node_addr  = 32'd5;
    fe_read_cost       = 32'd5;
    tick();
    fe_read_data_valid = 1'b0;
    check("rstw_no_pv", 64'(pop_valid), 64'h0);
    tick();
    check("rstw_no_pv2", 64'(pop_valid), 64'h0);
    check("rstw_idle", 64'(pop_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
